// File: rtl/encode_cxa_pkg.sv
// Shared definitions for the tank level encoder and its decoder:
// level code constants, FSM state encoding and the thermometer classifier.
package encode_cxa_pkg;

  localparam logic [2:0] NV_VAZIO = 3'b000;
  localparam logic [2:0] NV_1     = 3'b001;
  localparam logic [2:0] NV_2     = 3'b010;
  localparam logic [2:0] NV_3     = 3'b011;
  localparam logic [2:0] NV_CHEIO = 3'b100;
  localparam logic [2:0] NV_FALHA = 3'b111;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_TRACK  = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  typedef struct packed {
    logic       ok;
    logic [2:0] code;
  } level_t;

  // Map a wet/dry switch pattern to a level; anything that is not a
  // thermometer code (a wet switch above a dry one) is physically impossible.
  function automatic level_t classify(input logic [3:0] pat);
    level_t r;
    case (pat)
      4'b0000: r = '{ok: 1'b1, code: NV_VAZIO};
      4'b0001: r = '{ok: 1'b1, code: NV_1};
      4'b0011: r = '{ok: 1'b1, code: NV_2};
      4'b0111: r = '{ok: 1'b1, code: NV_3};
      4'b1111: r = '{ok: 1'b1, code: NV_CHEIO};
      default: r = '{ok: 1'b0, code: NV_FALHA};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/encode_cxa_debounce_vec.sv
// Width-N two-flop synchroniser plus debounce counter. Emits the current
// candidate pattern and a one-cycle accept strobe once the pattern has been
// stable for DEBOUNCE_CYCLES cycles. Each stable pattern is accepted once.
module debounce_vec #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] cand_o,
  output logic         accept_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1_q, sync2_q;
  logic [1:0]       vld_q;        // synchroniser fill tracking after reset
  logic [W-1:0]     cand_q, cand_d;
  logic             cand_vld_q, cand_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             accept_s;

  // Accept once: pattern stable, count reached, not yet accepted.
  assign accept_s = vld_q[1] && cand_vld_q && (sync2_q == cand_q) &&
                    (cnt_q == CNT_MAX) && !acc_q;

  // Debounce next-state: reload on any difference, else count and saturate.
  always_comb begin
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    if (!vld_q[1]) begin
      // Synchroniser output is not yet meaningful after reset.
      cnt_d = '0;
    end else if (!cand_vld_q || (sync2_q != cand_q)) begin
      cand_d     = sync2_q;
      cand_vld_d = 1'b1;
      cnt_d      = '0;
      acc_d      = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      if (accept_s) begin
        acc_d = 1'b1;
      end else begin
        acc_d = acc_q;
      end
    end
  end

  // Synchroniser, fill tracking and debounce state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      vld_q      <= 2'b00;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
    end else begin
      sync1_q    <= d_i;
      sync2_q    <= sync1_q;
      vld_q      <= {vld_q[0], 1'b1};
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
    end
  end

  assign cand_o   = cand_q;
  assign accept_o = accept_s;

endmodule

// File: rtl/encode_cxa.sv
// Tank level encoder: debounces four float switches, classifies the
// thermometer pattern and drives a registered level code with valid,
// change and fault flags.
module encode_cxa
  import encode_cxa_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Sens,
  output logic       Nv2,
  output logic       Nv1,
  output logic       Nv0,
  output logic       NvValid,
  output logic       NvChg,
  output logic       Fault
);

  logic [3:0] cand_s;
  logic       accept_s;
  level_t     lvl_s;

  state_e     state_q, state_d;
  logic [2:0] nv_q, nv_d;
  logic       valid_q, valid_d;
  logic       chg_q, chg_d;
  logic       fault_q, fault_d;

  debounce_vec #(
    .W               (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk_i    (clk),
    .rst_i    (rst),
    .d_i      (Sens),
    .cand_o   (cand_s),
    .accept_o (accept_s)
  );

  assign lvl_s = classify(cand_s);

  // Next-state and output logic; only an accept strobe can move anything.
  always_comb begin
    state_d = state_q;
    nv_d    = nv_q;
    valid_d = valid_q;
    fault_d = fault_q;
    chg_d   = 1'b0;
    if (accept_s) begin
      if (lvl_s.ok) begin
        state_d = ST_TRACK;
        nv_d    = lvl_s.code;
        valid_d = 1'b1;
        fault_d = 1'b0;
        case (state_q)
          ST_SETTLE: chg_d = 1'b1;   // first level after reset always announced
          ST_TRACK:  chg_d = (lvl_s.code != nv_q);
          ST_FAULT:  chg_d = 1'b1;   // leaving 111 is always a change
          default:   chg_d = 1'b1;
        endcase
      end else begin
        state_d = ST_FAULT;
        nv_d    = NV_FALHA;
        valid_d = 1'b0;
        fault_d = 1'b1;
        chg_d   = (nv_q != NV_FALHA);
      end
    end else begin
      chg_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SETTLE;
      nv_q    <= NV_VAZIO;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nv_q    <= nv_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      fault_q <= fault_d;
    end
  end

  assign {Nv2, Nv1, Nv0} = nv_q;
  assign NvValid         = valid_q;
  assign NvChg           = chg_q;
  assign Fault           = fault_q;

endmodule

// File: tb/tb_encode_cxa.sv
// Scoreboard bench for encode_cxa with DEBOUNCE_CYCLES=4 (7-edge latency).
module tb_encode_cxa;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Sens = 4'b0000;
  logic       Nv2, Nv1, Nv0, NvValid, NvChg, Fault;

  encode_cxa #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .Sens    (Sens),
    .Nv2     (Nv2),
    .Nv1     (Nv1),
    .Nv0     (Nv0),
    .NvValid (NvValid),
    .NvChg   (NvChg),
    .Fault   (Fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] nv;
    logic       v;
    logic       f;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: count edges, and on every NvChg pop and compare the expectation.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (NvChg === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_chg: got cyc=%0d nv=%b v=%b f=%b, expected no NvChg",
                   cyc, {Nv2, Nv1, Nv0}, NvValid, Fault);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (cyc != e.cyc || {Nv2, Nv1, Nv0} !== e.nv || NvValid !== e.v || Fault !== e.f) begin
            errors++;
            $display("FAIL %s: got cyc=%0d nv=%b v=%b f=%b, expected cyc=%0d nv=%b v=%b f=%b",
                     e.name, cyc, {Nv2, Nv1, Nv0}, NvValid, Fault, e.cyc, e.nv, e.v, e.f);
          end
        end
      end
    end
  end

  // Apply a pattern just after a falling edge; optionally push the expected result 7 edges on.
  task automatic apply(input logic [3:0] v, input bit exp_en, input logic [2:0] nv,
                       input logic ev, input logic ef, input string name);
    exp_t e;
    @(negedge clk);
    Sens = v;
    if (exp_en) begin
      e.cyc = cyc + 7; e.nv = nv; e.v = ev; e.f = ef; e.name = name;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_state(input string name, input logic [2:0] nv, input logic v,
                           input logic c, input logic f);
    checks++;
    if ({Nv2, Nv1, Nv0} !== nv || NvValid !== v || NvChg !== c || Fault !== f) begin
      errors++;
      $display("FAIL %s: got nv=%b v=%b c=%b f=%b, expected nv=%b v=%b c=%b f=%b",
               name, {Nv2, Nv1, Nv0}, NvValid, NvChg, Fault, nv, v, c, f);
    end
  endtask

  initial begin
    exp_t e;
    // Reset and settle at empty.
    rst = 1'b1; Sens = 4'b0000;
    wait_cyc(3);
    chk_state("reset_state", 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    e.cyc = cyc + 7; e.nv = 3'b000; e.v = 1'b1; e.f = 1'b0; e.name = "settle_empty";
    sbq.push_back(e);
    wait_cyc(4);
    chk_state("pre_accept", 3'b000, 1'b0, 1'b0, 1'b0);
    wait_cyc(6);
    chk_state("settled_empty", 3'b000, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a debounce: everything back to zero.
    apply(4'b0011, 1'b0, 3'b000, 1'b0, 1'b0, "");
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(2);
    chk_state("mid_reset", 3'b000, 1'b0, 1'b0, 1'b0);
    Sens = 4'b0000;
    rst  = 1'b0;
    e.cyc = cyc + 7; e.nv = 3'b000; e.v = 1'b1; e.f = 1'b0; e.name = "resettle_empty";
    sbq.push_back(e);
    wait_cyc(10);

    // Level 0 -> level 2.
    apply(4'b0011, 1'b1, 3'b010, 1'b1, 1'b0, "to_level2");
    wait_cyc(10);
    apply(4'b0000, 1'b1, 3'b000, 1'b1, 1'b0, "back_empty");
    wait_cyc(10);

    // Bounce between 0011 and 0001 every 2 cycles, then hold 0011.
    for (int i = 0; i < 10; i++) begin
      apply((i % 2 == 0) ? 4'b0011 : 4'b0001, 1'b0, 3'b000, 1'b0, 1'b0, "");
      wait_cyc(1);
    end
    apply(4'b0011, 1'b1, 3'b010, 1'b1, 1'b0, "bounce_hold");
    wait_cyc(10);

    // Invalid pattern into FAULT, then recovery at level 3.
    apply(4'b0101, 1'b1, 3'b111, 1'b0, 1'b1, "fault_entry");
    wait_cyc(10);
    chk_state("fault_steady", 3'b111, 1'b0, 1'b0, 1'b1);
    apply(4'b0111, 1'b1, 3'b011, 1'b1, 1'b0, "fault_exit");
    wait_cyc(10);

    // Full sweep down to empty, up to full and back down.
    begin
      logic [3:0] pats  [9];
      logic [2:0] codes [9];
      pats  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
      codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};
      for (int i = 0; i < 9; i++) begin
        apply(pats[i], 1'b1, codes[i], 1'b1, 1'b0, $sformatf("sweep_%0d", i));
        wait_cyc(9);
      end
    end

    // Same-level re-accept after a short glitch: no change expected.
    apply(4'b0111, 1'b1, 3'b011, 1'b1, 1'b0, "to_level3");
    wait_cyc(10);
    apply(4'b1111, 1'b0, 3'b000, 1'b0, 1'b0, "");
    wait_cyc(1);
    apply(4'b0111, 1'b0, 3'b000, 1'b0, 1'b0, "");
    wait_cyc(14);
    chk_state("reaccept_level3", 3'b011, 1'b1, 1'b0, 1'b0);

    // All expected changes must have been seen.
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_chg: got %0d expectations left, expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
